logic_gates: RTL and testbench

//   Registered two-input logic-gate bank. Computes all eight basic bitwise

---
 rtl/logic_gates_pkg.sv | 15 +
 rtl/logic_gates_gate_slice.sv | 22 ++
 rtl/logic_gates.sv | 62 ++++++
 tb/tb_logic_gates.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/logic_gates_pkg.sv
// Shared constants for the registered logic-gate bank: gate index map and gate count.
package logic_gates_pkg;

   localparam int NUM_GATES = 8;

   localparam int GATE_AND  = 0;
   localparam int GATE_OR   = 1;
   localparam int GATE_NAND = 2;
   localparam int GATE_NOR  = 3;
   localparam int GATE_XOR  = 4;
   localparam int GATE_XNOR = 5;
   localparam int GATE_NOTA = 6;
   localparam int GATE_NOTB = 7;

endpackage : logic_gates_pkg

// File: rtl/logic_gates_gate_slice.sv
// One bit position of the gate bank: evaluates all eight gates of a single a/b bit pair.
module gate_slice
   import logic_gates_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] g
);

   always_comb begin
      g            = '0;
      g[GATE_AND]  = a & b;
      g[GATE_OR]   = a | b;
      g[GATE_NAND] = ~(a & b);
      g[GATE_NOR]  = ~(a | b);
      g[GATE_XOR]  = a ^ b;
      g[GATE_XNOR] = ~(a ^ b);
      g[GATE_NOTA] = ~a;
      g[GATE_NOTB] = ~b;
   end

endmodule : gate_slice

// File: rtl/logic_gates.sv
// Registered two-input gate bank: WIDTH gate slices feed one 8*WIDTH result register.
module logic_gates
   import logic_gates_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       en,
   input  logic [WIDTH-1:0]           A,
   input  logic [WIDTH-1:0]           B,
   output logic [NUM_GATES*WIDTH-1:0] Y,
   output logic                       y_vld
);

   logic [NUM_GATES-1:0]       slice_g [WIDTH];
   logic [NUM_GATES*WIDTH-1:0] y_scatter;

   logic [NUM_GATES*WIDTH-1:0] y_d, y_q;
   logic                       y_vld_d, y_vld_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      gate_slice u_gate_slice (
         .a (A[i]),
         .b (B[i]),
         .g (slice_g[i])
      );
   end

   // Bit i of gate g lands in field g, so each field reads as a WIDTH-bit gate result.
   always_comb begin
      y_scatter = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         for (int i = 0; i < WIDTH; i++) begin
            y_scatter[g*WIDTH + i] = slice_g[i][g];
         end
      end
   end

   always_comb begin
      y_d     = y_q;
      y_vld_d = y_vld_q;
      if (en) begin
         y_d     = y_scatter;
         y_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         y_q     <= '0;
         y_vld_q <= 1'b0;
      end else begin
         y_q     <= y_d;
         y_vld_q <= y_vld_d;
      end
   end

   assign Y     = y_q;
   assign y_vld = y_vld_q;

endmodule : logic_gates

// File: tb/tb_logic_gates.sv
// Directed bench for logic_gates at WIDTH=1 and WIDTH=4, plus a short randomized scoreboard run.
module tb_logic_gates;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        a1, b1;
   logic [3:0]  a4, b4;
   logic [7:0]  y1;
   logic        vld1;
   logic [31:0] y4;
   logic        vld4;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [31:0] exp_q [$];

   logic_gates #(.WIDTH(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .A     (a1),
      .B     (b1),
      .Y     (y1),
      .y_vld (vld1)
   );

   logic_gates #(.WIDTH(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .A     (a4),
      .B     (b4),
      .Y     (y4),
      .y_vld (vld4)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] ref1(input logic a, input logic b);
      return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   function automatic logic [31:0] ref4(input logic [3:0] a, input logic [3:0] b);
      return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
   endfunction

   logic [7:0]  vec_ab   [4];
   logic [7:0]  vec_y    [4];
   logic [3:0]  field_exp[8];
   string       field_nm [8];

   initial begin
      logic [7:0]  exp1;
      logic [31:0] exp4;
      logic        exp_vld;
      logic [31:0] e;

      vec_ab = '{8'h00, 8'h01, 8'h02, 8'h03};
      vec_y  = '{8'hEC, 8'h56, 8'h96, 8'h23};
      field_exp = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                    4'b0110, 4'b1001, 4'b0011, 4'b0101};
      field_nm  = '{"and4", "or4", "nand4", "nor4", "xor4", "xnor4", "nota4", "notb4"};

      // reset held for two edges with live inputs
      rst_n = 1'b0; en = 1'b1; a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
      for (int k = 0; k < 2; k++) begin
         tick();
         check("rst_y1",   32'(y1),   32'h0);
         check("rst_vld1", 32'(vld1), 32'h0);
         check("rst_y4",   y4,        32'h0);
      end

      // truth table, one result per edge
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a1 = vec_ab[k][1];
         b1 = vec_ab[k][0];
         tick();
         check($sformatf("tt_y_%0d", k), 32'(y1),   32'(vec_y[k]));
         check($sformatf("tt_vld_%0d", k), 32'(vld1), 32'h1);
      end

      // hold with en low
      en = 1'b0; a1 = 1'b0; b1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("hold_y_%0d", k), 32'(y1),   32'h23);
         check($sformatf("hold_vld_%0d", k), 32'(vld1), 32'h1);
      end

      // reset wins over en on the same edge
      rst_n = 1'b0; en = 1'b1; a1 = 1'b0; b1 = 1'b1;
      tick();
      check("rst_win_y",   32'(y1),   32'h0);
      check("rst_win_vld", 32'(vld1), 32'h0);

      // first enabled edge after reset; WIDTH=4 field check
      rst_n = 1'b1; en = 1'b1; a4 = 4'b1100; b4 = 4'b1010; a1 = 1'b1; b1 = 1'b0;
      tick();
      check("post_rst_y1",  32'(y1),   32'h96);
      check("post_rst_vld", 32'(vld4), 32'h1);
      for (int g = 0; g < 8; g++) begin
         check(field_nm[g], 32'(y4[g*4 +: 4]), 32'(field_exp[g]));
      end
      check("w4_full", y4, 32'h539617E8);

      // randomized run against a one-cycle-delayed reference
      exp1    = 8'h96;
      exp4    = 32'h539617E8;
      exp_vld = 1'b1;
      for (int k = 0; k < 300; k++) begin
         a1 = 1'($urandom_range(0, 1));
         b1 = 1'($urandom_range(0, 1));
         a4 = 4'($urandom_range(0, 15));
         b4 = 4'($urandom_range(0, 15));
         en = 1'($urandom_range(0, 1));
         if (en) begin
            exp1 = ref1(a1, b1);
            exp4 = ref4(a4, b4);
         end
         exp_q.push_back(32'(exp1));
         exp_q.push_back(exp4);
         tick();
         e = exp_q.pop_front();
         check("rand_y1", 32'(y1), e);
         e = exp_q.pop_front();
         check("rand_y4", y4, e);
         check("rand_vld", 32'(vld1 & vld4), 32'(exp_vld));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_logic_gates
